// File: rtl/tick_timer_pkg.sv
// Shared types for the tick-driven BCD timer: FSM states, BCD nibble type and increment helper.
package tick_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Wraps 9 (or any illegal nibble) back to 0 so a digit can never leave the BCD range.
  function automatic bcd_t bcd_inc(input bcd_t v);
    return (v >= BCD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer count. Increments on inc_in and produces a carry
// into the next digit when it wraps from 9.
import tick_timer_pkg::*;

module bcd_digit (
  input  logic clock,
  input  logic reset_n,
  input  logic inc_in,
  input  logic clr,
  output bcd_t q,
  output logic carry_out
);

  // Digit register: clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc_in) begin
      q <= bcd_inc(q);
    end
  end

  assign carry_out = (q == BCD_MAX) & inc_in;

endmodule

// File: rtl/tick_bcd_timer.sv
// BCD tick timer: synchronises scaledclk (data only), turns each rising edge into a
// one-cycle tick and counts ticks in packed BCD under start/stop/clear control.
// Optional build macro LAP_HOLD_EN adds a lap/hold register in front of the digits output.
import tick_timer_pkg::*;

module tick_bcd_timer #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    scaledclk,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    prev_q;
  logic                    tick;
  timer_state_t            state_q;
  logic                    running_q;
  logic                    overflow_q;
  logic [4*NUM_DIGITS-1:0] count_q;
  logic [NUM_DIGITS:0]     inc_chain;
  logic                    all_nines;
  logic                    unused_carry;

  // Synchroniser chain and previous-value flop for rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scaledclk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Detect the terminal count so the final tick drives OVF instead of wrapping.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (count_q[4*i +: 4] != BCD_MAX) all_nines = 1'b0;
    end
  end

  // A tick alongside start_stop in RUN still counts; clear discards it.
  assign inc_chain[0] = tick & (state_q == RUN) & ~clear & ~all_nines;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .reset_n   (reset_n),
      .inc_in    (inc_chain[g]),
      .clr       (clear),
      .q         (count_q[4*g +: 4]),
      .carry_out (inc_chain[g+1])
    );
  end

  assign unused_carry = inc_chain[NUM_DIGITS];

  // Control FSM with registered status outputs; clear > start_stop > tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (tick && all_nines) begin
            state_q    <= OVF;
            running_q  <= 1'b0;
            overflow_q <= 1'b1;
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        OVF: begin
          // Only clear leaves OVF.
        end
        default: begin
          state_q    <= IDLE;
          running_q  <= 1'b0;
          overflow_q <= 1'b0;
        end
      endcase
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef LAP_HOLD_EN
  logic                    hold_q;
  logic                    hold_d;
  logic [4*NUM_DIGITS-1:0] count_d;
  logic [4*NUM_DIGITS-1:0] digits_q;

  // Next count value, so the display register tracks the count on the same edge.
  always_comb begin
    count_d = count_q;
    hold_d  = clear ? 1'b0 : (hold_q ^ lap);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (clear) begin
        count_d[4*i +: 4] = '0;
      end else if (inc_chain[i]) begin
        count_d[4*i +: 4] = bcd_inc(count_q[4*i +: 4]);
      end
    end
  end

  // Display register freezes while hold is set and shows the live count otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      hold_q <= hold_d;
      if (clear) begin
        digits_q <= '0;
      end else if (!hold_d) begin
        digits_q <= count_d;
      end
    end
  end

  assign digits = digits_q;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign digits     = count_q;
`endif

endmodule
